// File: rtl/conv_requant_scale.sv
// Per-channel requantiser: lane*scale, rounding >>> shift, +zero point, saturate to OUT_W.
// Latency MULT_STAGES+3 cycles from accept to m_valid; one beat per cycle when m_ready=1.
// Global stall: every stage freezes while m_valid&&!m_ready; config loads only when idle.
module conv_requant_scale #(
    parameter int PIC_NUM     = 2,
    parameter int CH_NUM      = 8,
    parameter int DATA_W      = 32,
    parameter int SCALE_W     = 32,
    parameter int SHIFT_W     = 6,
    parameter int OUT_W       = 8,
    parameter int MULT_STAGES = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [PIC_NUM*CH_NUM*DATA_W-1:0]    s_data,
    input  logic                                cfg_load,
    output logic                                cfg_ready,
    input  logic [CH_NUM*SCALE_W-1:0]           scale_in,
    input  logic [CH_NUM*SHIFT_W-1:0]           shift_in,
    input  logic [OUT_W-1:0]                    zp_in,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [PIC_NUM*CH_NUM*OUT_W-1:0]     m_data,
    output logic                                busy
);
    localparam int LANES = PIC_NUM * CH_NUM;
    localparam int PW    = DATA_W + SCALE_W;
    localparam logic signed [PW+1:0] SAT_MAX = (PW+2)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PW+1:0] SAT_MIN = (PW+2)'(-(2 ** (OUT_W - 1)));

    logic                        en;
    logic                        cfg_cap;
    logic signed [SCALE_W-1:0]   scale_q [CH_NUM];
    logic        [SHIFT_W-1:0]   shift_q [CH_NUM];
    logic signed [OUT_W-1:0]     zp_q;

    logic                        in_vld;
    logic signed [DATA_W-1:0]    in_dat  [LANES];
    logic [MULT_STAGES-1:0]      mul_vld;
    logic signed [PW-1:0]        mul_dat [MULT_STAGES][LANES];
    logic                        rnd_vld;
    logic signed [PW:0]          rnd_dat [LANES];
    logic                        zp_vld;
    logic signed [PW+1:0]        zp_dat  [LANES];

    // Rounding bias is added one bit wider than the product so it can never wrap.
    function automatic logic signed [PW:0] round_shift(input logic signed [PW-1:0] p,
                                                       input logic [SHIFT_W-1:0] sh);
        logic signed [PW:0] pe;
        logic signed [PW:0] bias;
        pe   = (PW+1)'(p);
        bias = '0;
        if (sh != '0)
            bias[sh - 1'b1] = 1'b1;
        return (pe + bias) >>> sh;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [PW+1:0] y);
        if (y > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (y < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return y[OUT_W-1:0];
    endfunction

    assign busy      = in_vld | (|mul_vld) | rnd_vld | zp_vld | m_valid;
    assign cfg_ready = !busy;
    assign cfg_cap   = cfg_load && cfg_ready;
    assign en        = !m_valid || m_ready;
    assign s_ready   = en && !cfg_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < CH_NUM; j++) begin
                scale_q[j] <= '0;
                shift_q[j] <= '0;
            end
            zp_q <= '0;
        end else if (cfg_cap) begin
            for (int j = 0; j < CH_NUM; j++) begin
                scale_q[j] <= scale_in[j*SCALE_W +: SCALE_W];
                shift_q[j] <= shift_in[j*SHIFT_W +: SHIFT_W];
            end
            zp_q <= zp_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_vld  <= 1'b0;
            mul_vld <= '0;
            rnd_vld <= 1'b0;
            zp_vld  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            for (int l = 0; l < LANES; l++) begin
                in_dat[l]  <= '0;
                rnd_dat[l] <= '0;
                zp_dat[l]  <= '0;
                for (int s = 0; s < MULT_STAGES; s++)
                    mul_dat[s][l] <= '0;
            end
        end else if (en) begin
            in_vld     <= s_valid && s_ready;
            mul_vld[0] <= in_vld;
            for (int s = 1; s < MULT_STAGES; s++)
                mul_vld[s] <= mul_vld[s-1];
            rnd_vld <= mul_vld[MULT_STAGES-1];
            zp_vld  <= rnd_vld;
            m_valid <= zp_vld;
            for (int l = 0; l < LANES; l++) begin
                in_dat[l]     <= s_data[l*DATA_W +: DATA_W];
                // Lanes are channel-major, so the channel of lane l is l / PIC_NUM.
                mul_dat[0][l] <= PW'(in_dat[l]) * PW'(scale_q[l / PIC_NUM]);
                for (int s = 1; s < MULT_STAGES; s++)
                    mul_dat[s][l] <= mul_dat[s-1][l];
                rnd_dat[l] <= round_shift(mul_dat[MULT_STAGES-1][l], shift_q[l / PIC_NUM]);
                zp_dat[l]  <= (PW+2)'(rnd_dat[l]) + (PW+2)'(zp_q);
                m_data[l*OUT_W +: OUT_W] <= saturate(zp_dat[l]);
            end
        end
    end
endmodule

// File: tb/tb_conv_requant_scale.sv
// Directed bench for conv_requant_scale with hand-computed expected outputs.
module tb_conv_requant_scale;
    localparam int P  = 2;
    localparam int C  = 8;
    localparam int DW = 32;
    localparam int SW = 32;
    localparam int HW = 6;
    localparam int OW = 8;
    localparam int MS = 3;
    localparam int L  = MS + 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic [P*C*DW-1:0]    s_data;
    logic                 cfg_load;
    logic                 cfg_ready;
    logic [C*SW-1:0]      scale_in;
    logic [C*HW-1:0]      shift_in;
    logic [OW-1:0]        zp_in;
    logic                 m_valid;
    logic                 m_ready;
    logic [P*C*OW-1:0]    m_data;
    logic                 busy;

    int nvec = 0;
    int nerr = 0;

    conv_requant_scale #(
        .PIC_NUM(P), .CH_NUM(C), .DATA_W(DW), .SCALE_W(SW),
        .SHIFT_W(HW), .OUT_W(OW), .MULT_STAGES(MS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_load(cfg_load), .cfg_ready(cfg_ready),
        .scale_in(scale_in), .shift_in(shift_in), .zp_in(zp_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [P*C*DW-1:0] rep_in(input int v);
        logic [P*C*DW-1:0] r;
        for (int l = 0; l < P*C; l++) r[l*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [P*C*OW-1:0] rep_out(input int v);
        logic [P*C*OW-1:0] r;
        for (int l = 0; l < P*C; l++) r[l*OW +: OW] = v[OW-1:0];
        return r;
    endfunction

    function automatic logic [C*SW-1:0] u_scale(input int v);
        logic [C*SW-1:0] r;
        for (int j = 0; j < C; j++) r[j*SW +: SW] = v;
        return r;
    endfunction

    function automatic logic [C*HW-1:0] u_shift(input int v);
        logic [C*HW-1:0] r;
        for (int j = 0; j < C; j++) r[j*HW +: HW] = v[HW-1:0];
        return r;
    endfunction

    // Holds cfg_load until cfg_ready, then releases it just after the capture edge.
    task automatic load_cfg(input logic [C*SW-1:0] sc, input logic [C*HW-1:0] sh, input logic [OW-1:0] zp);
        int n;
        @(negedge clk);
        scale_in = sc; shift_in = sh; zp_in = zp; cfg_load = 1'b1;
        #1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!cfg_ready) begin
            nvec++; nerr++;
            $display("FAIL cfg_timeout: cfg_ready=%0b after %0d cycles, required 1", cfg_ready, n);
        end
        @(posedge clk);
        #1 cfg_load = 1'b0;
    endtask

    // Sends one beat with m_ready=1; lat is edges from accept to m_valid, -1 on timeout.
    task automatic send_beat(input logic [P*C*DW-1:0] d, output int lat);
        int n;
        @(negedge clk);
        m_ready = 1'b1; s_valid = 1'b1; s_data = d;
        #1;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; cfg_load = 1'b0;
        scale_in = '0; shift_in = '0; zp_in = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if ({m_valid, s_ready, cfg_ready, busy} !== 4'b0110 || m_data !== '0) begin
            nerr++;
            $display("FAIL reset_state: m_valid=%0b s_ready=%0b cfg_ready=%0b busy=%0b m_data=%h, required 0 1 1 0 0",
                     m_valid, s_ready, cfg_ready, busy, m_data);
        end
        rst = 1'b0;
        send_beat(rep_in(55), lat);
        nvec++;
        if (lat != L || m_data !== rep_out(0)) begin
            nerr++;
            $display("FAIL reset_cfg_zero: lat=%0d data=%h, required lat=%0d data=0", lat, m_data, L);
        end
    endtask

    task automatic test_basic();
        int lat;
        load_cfg(u_scale(3), u_shift(2), 8'd0);
        send_beat(rep_in(100), lat);
        nvec++;
        if (lat != L) begin
            nerr++;
            $display("FAIL latency: got %0d cycles, required %0d", lat, L);
        end
        nvec++;
        if (m_data !== rep_out(75)) begin
            nerr++;
            $display("FAIL basic_scale: got %h, required %h", m_data, rep_out(75));
        end
    endtask

    task automatic test_rounding();
        int lat;
        int vin  [3] = '{-5, 5, -4};
        int vexp [3] = '{-2, 3, -2};
        load_cfg(u_scale(1), u_shift(1), 8'd0);
        for (int t = 0; t < 3; t++) begin
            send_beat(rep_in(vin[t]), lat);
            nvec++;
            if (lat != L || m_data !== rep_out(vexp[t])) begin
                nerr++;
                $display("FAIL round_%0d: lat=%0d data=%h, required lat=%0d data=%h",
                         vin[t], lat, m_data, L, rep_out(vexp[t]));
            end
        end
        load_cfg(u_scale(1), u_shift(0), 8'd0);
        send_beat(rep_in(7), lat);
        nvec++;
        if (m_data !== rep_out(7)) begin
            nerr++;
            $display("FAIL shift0: got %h, required %h", m_data, rep_out(7));
        end
        // 2^30 * 2^20 = 2^50, >>> 46 gives 16: needs the full-width product.
        load_cfg(u_scale(32'h4000_0000), u_shift(46), 8'd0);
        send_beat(rep_in(32'h0010_0000), lat);
        nvec++;
        if (m_data !== rep_out(16)) begin
            nerr++;
            $display("FAIL wide_product: got %h, required %h", m_data, rep_out(16));
        end
    endtask

    task automatic test_saturation();
        int lat;
        int vin  [6] = '{1000, -1000, 120, -140, 5, -20};
        int vexp [6] = '{127, -128, 127, -128, 15, -10};
        for (int t = 0; t < 6; t++) begin
            if (t == 0) load_cfg(u_scale(1), u_shift(0), 8'd0);
            if (t == 2) load_cfg(u_scale(1), u_shift(0), 8'd10);
            send_beat(rep_in(vin[t]), lat);
            nvec++;
            if (m_data !== rep_out(vexp[t])) begin
                nerr++;
                $display("FAIL sat_%0d: got %h, required %h", vin[t], m_data, rep_out(vexp[t]));
            end
        end
    endtask

    task automatic test_channels();
        int lat;
        logic [C*SW-1:0]   sc;
        logic [P*C*OW-1:0] ex;
        for (int j = 0; j < C; j++) begin
            sc[j*SW +: SW] = j + 1;
            for (int i = 0; i < P; i++) ex[(j*P+i)*OW +: OW] = 8'(10 * (j + 1));
        end
        load_cfg(sc, u_shift(0), 8'd0);
        send_beat(rep_in(10), lat);
        nvec++;
        if (m_data !== ex) begin
            nerr++;
            $display("FAIL per_channel: got %h, required %h", m_data, ex);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        logic [P*C*OW-1:0] held = '0;
        logic stalled_prev = 1'b0;
        load_cfg(u_scale(1), u_shift(0), 8'd0);
        for (int c = 0; c < 80 && got < 10; c++) begin
            @(negedge clk);
            m_ready = !(c >= 8 && c < 13);
            s_valid = (sent < 10);
            s_data  = rep_in(sent + 1);
            #1;
            if (!m_ready) begin
                nvec++;
                if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
                    nerr++;
                    $display("FAIL stall_ready c=%0d: s_ready=%0b m_valid=%0b, required 0 1", c, s_ready, m_valid);
                end
                if (stalled_prev) begin
                    nvec++;
                    if (m_data !== held) begin
                        nerr++;
                        $display("FAIL stall_hold c=%0d: got %h, required %h", c, m_data, held);
                    end
                end
            end
            if (m_valid && m_ready) begin
                nvec++;
                if (m_data !== rep_out(got + 1)) begin
                    nerr++;
                    $display("FAIL stream_order %0d: got %h, required %h", got, m_data, rep_out(got + 1));
                end
                got++;
            end
            stalled_prev = m_valid && !m_ready;
            if (stalled_prev) held = m_data;
            if (s_valid && s_ready) sent++;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        nvec++;
        if (got != 10 || sent != 10) begin
            nerr++;
            $display("FAIL stream_count: got %0d sent %0d, required 10 10", got, sent);
        end
        repeat (2) @(negedge clk);
        nvec++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL stream_drain: m_valid=%0b busy=%0b, required 0 0", m_valid, busy);
        end
    endtask

    task automatic test_cfg_gating();
        int lat;
        bit seen;
        load_cfg(u_scale(2), u_shift(0), 8'd0);
        // Single pulse while a beat is in flight must be dropped.
        @(negedge clk);
        s_valid = 1'b1; s_data = rep_in(10); m_ready = 1'b1;
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        scale_in = u_scale(5); cfg_load = 1'b1;
        #1;
        nvec++;
        if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL cfg_busy: cfg_ready=%0b busy=%0b, required 0 1", cfg_ready, busy);
        end
        @(posedge clk); #1 cfg_load = 1'b0;
        repeat (L + 2) @(negedge clk);
        send_beat(rep_in(10), lat);
        nvec++;
        if (m_data !== rep_out(20)) begin
            nerr++;
            $display("FAIL cfg_pulse_ignored: got %h, required %h", m_data, rep_out(20));
        end
        repeat (2) @(negedge clk);
        // Held request: in-flight beat keeps old scale, capture waits for idle.
        s_valid = 1'b1; s_data = rep_in(10);
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        scale_in = u_scale(5); cfg_load = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            #1;
            if (m_valid) begin
                seen = 1'b1;
                nvec++;
                if (m_data !== rep_out(20)) begin
                    nerr++;
                    $display("FAIL cfg_inflight_old: got %h, required %h", m_data, rep_out(20));
                end
            end
            if (cfg_ready) break;
            @(negedge clk);
        end
        s_valid = 1'b1; s_data = rep_in(99);
        #1;
        nvec++;
        if (cfg_ready !== 1'b1 || s_ready !== 1'b0 || !seen) begin
            nerr++;
            $display("FAIL cfg_capture_cycle: cfg_ready=%0b s_ready=%0b seen_out=%0b, required 1 0 1",
                     cfg_ready, s_ready, seen);
        end
        @(posedge clk); #1 begin cfg_load = 1'b0; s_valid = 1'b0; end
        send_beat(rep_in(10), lat);
        nvec++;
        if (m_data !== rep_out(50)) begin
            nerr++;
            $display("FAIL cfg_new_scale: got %h, required %h", m_data, rep_out(50));
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        load_cfg(u_scale(1), u_shift(0), 8'd0);
        @(negedge clk);
        s_valid = 1'b1; s_data = rep_in(9); m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL pre_reset_busy: busy=%0b, required 1", busy);
        end
        rst = 1'b1;
        #1;
        nvec++;
        if ({m_valid, busy, s_ready, cfg_ready} !== 4'b0011 || m_data !== '0) begin
            nerr++;
            $display("FAIL mid_reset: m_valid=%0b busy=%0b s_ready=%0b cfg_ready=%0b m_data=%h, required 0 0 1 1 0",
                     m_valid, busy, s_ready, cfg_ready, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        send_beat(rep_in(33), lat);
        nvec++;
        if (lat != L || m_data !== rep_out(0)) begin
            nerr++;
            $display("FAIL post_reset_zero: lat=%0d data=%h, required lat=%0d data=0", lat, m_data, L);
        end
        load_cfg(u_scale(1), u_shift(0), 8'd0);
        send_beat(rep_in(33), lat);
        nvec++;
        if (m_data !== rep_out(33)) begin
            nerr++;
            $display("FAIL post_reset_reload: got %h, required %h", m_data, rep_out(33));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_channels();
        test_back_to_back();
        test_cfg_gating();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
